// File: rtl/jt900h_regs.sv
// Register bank and flag store fed by the ALU: four banked XWA/XBC/XDE/XHL sets,
// fixed XIX/XIY/XIZ/XSP, bank pointer RFP, F/F' flags and two combinational read ports.
`timescale 1ns/1ps
module jt900h_regs #(
    parameter logic [31:0] SP_RST = 32'h0000_0100
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [7:0]  dst,
    input  logic [2:0]  alu_we,
    input  logic [31:0] alu_dout,
    input  logic [7:0]  alu_flags,
    input  logic        flag_only,
    input  logic        incf,
    input  logic        decf,
    input  logic        ex_f,
    input  logic [7:0]  src0_addr,
    input  logic [7:0]  src1_addr,
    output logic [31:0] src0,
    output logic [31:0] src1,
    output logic [7:0]  f,
    output logic [1:0]  rfp
);

    // Physical slots 0-15 are the banked registers (bank*4 + reg), 16-19 XIX/XIY/XIZ/XSP.
    localparam int NREGS = 20;

    logic [31:0] regs_q [NREGS];
    logic [7:0]  dst_l_q;
    logic [7:0]  f_q, f_d;
    logic [7:0]  falt_q, falt_d;
    logic [1:0]  rfp_q, rfp_d;

    logic [5:0]  wr_sel;
    logic [5:0]  rd0_sel;
    logic [5:0]  rd1_sel;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic [31:0] rd0_word;
    logic [31:0] rd1_word;
    logic        flag_upd;

    // Maps a register code to {valid, slot}; bank aliases use the given RFP.
    function automatic logic [5:0] resolve(input logic [7:0] code, input logic [1:0] bank);
        logic [1:0] prev;
        logic [5:0] sel;
        prev = bank - 2'd1;
        sel  = 6'd0;
        case (code[7:4])
            4'h0, 4'h1, 4'h2, 4'h3: sel = {2'b10, code[5:2]};
            4'hD:                   sel = {2'b10, prev, code[3:2]};
            4'hE:                   sel = {2'b10, bank, code[3:2]};
            4'hF:                   sel = {4'b1100, code[3:2]};
            default:                sel = 6'd0;
        endcase
        return sel;
    endfunction

    assign wr_sel  = resolve(dst_l_q, rfp_q);
    assign rd0_sel = resolve(src0_addr, rfp_q);
    assign rd1_sel = resolve(src1_addr, rfp_q);

    always_comb begin
        rd0_word = 32'd0;
        rd1_word = 32'd0;
        if (rd0_sel[5]) begin
            rd0_word = regs_q[rd0_sel[4:0]];
        end
        if (rd1_sel[5]) begin
            rd1_word = regs_q[rd1_sel[4:0]];
        end
    end

    assign src0 = rd0_word >> {src0_addr[1:0], 3'b000};
    assign src1 = rd1_word >> {src1_addr[1:0], 3'b000};

    // Widest strobe wins; data is replicated so each lane sees its own byte.
    always_comb begin
        wr_mask = 4'b0000;
        wr_data = alu_dout;
        if (alu_we[2]) begin
            wr_mask = 4'b1111;
        end else if (alu_we[1]) begin
            wr_mask = dst_l_q[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{alu_dout[15:0]}};
        end else if (alu_we[0]) begin
            wr_mask = 4'b0001 << dst_l_q[1:0];
            wr_data = {4{alu_dout[7:0]}};
        end
        if (!wr_sel[5]) begin
            wr_mask = 4'b0000;
        end
    end

    always_comb begin
        flag_upd = (|alu_we) | flag_only;
        f_d      = f_q;
        falt_d   = falt_q;
        if (flag_upd) begin
            f_d = alu_flags;
            if (ex_f) begin
                falt_d = f_q;
            end
        end else if (ex_f) begin
            f_d    = falt_q;
            falt_d = f_q;
        end
    end

    always_comb begin
        rfp_d = rfp_q;
        if (incf && !decf) begin
            rfp_d = rfp_q + 2'd1;
        end else if (decf && !incf) begin
            rfp_d = rfp_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == NREGS - 1) ? SP_RST : 32'd0;
            end
        end else if (cen) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    regs_q[wr_sel[4:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_l_q <= 8'd0;
            f_q     <= 8'd0;
            falt_q  <= 8'd0;
            rfp_q   <= 2'd0;
        end else if (cen) begin
            dst_l_q <= dst;
            f_q     <= f_d;
            falt_q  <= falt_d;
            rfp_q   <= rfp_d;
        end
    end

    assign f   = f_q;
    assign rfp = rfp_q;

endmodule
